gol_grid_reader: RTL and testbench

- Read-side counterpart to the game-of-life cell array: snapshots every cell's current state on request and streams the frame out row by row over a valid/ready interface.
- Sits between the cell grid and downstream consumers (display scan-out, UART dumper, checker).
- Decouples the grid's per-generation update from slow consumers; the snapshot is immune to later generations.

---
 rtl/gol_grid_reader.sv | 110 +++++++++++
 tb/tb_gol_grid_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gol_grid_reader.sv
// Snapshots the game-of-life grid on request and streams it out one row per beat over valid/ready.
// Optional live-cell population count: define GOL_READER_POPCOUNT_EN.
module gol_grid_reader #(
   parameter int WIDTH    = 8,
   parameter int HEIGHT   = 8,
   parameter int ROW_BITS = 3,
   parameter int POP_BITS = 7
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic [WIDTH*HEIGHT-1:0]   i_cells,
   input  logic                      i_capture,
   input  logic                      i_ready,
   output logic                      o_valid,
   output logic [WIDTH-1:0]          o_row_data,
   output logic [ROW_BITS-1:0]       o_row_idx,
   output logic                      o_last,
   output logic                      o_busy,
   output logic                      o_frame_done
`ifdef GOL_READER_POPCOUNT_EN
   ,
   output logic [POP_BITS-1:0]       o_population
`endif
);

   if (HEIGHT < 2 || (2**ROW_BITS) < HEIGHT || (2**POP_BITS) <= WIDTH*HEIGHT) begin : g_param_check
      $error("gol_grid_reader: inconsistent WIDTH/HEIGHT/ROW_BITS/POP_BITS");
   end

   typedef enum logic {IDLE, STREAM} state_t;

   localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(HEIGHT - 1);

   state_t              state;
   logic [WIDTH-1:0]    snap [HEIGHT];
   logic [ROW_BITS-1:0] row;
   logic                frame_done;
   logic                streaming;
   logic                xfer;

   assign streaming = (state == STREAM);
   assign xfer      = streaming && i_ready;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state      <= IDLE;
         row        <= '0;
         frame_done <= 1'b0;
         for (int r = 0; r < HEIGHT; r++) snap[r] <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (i_capture) begin
                  for (int r = 0; r < HEIGHT; r++) snap[r] <= i_cells[r*WIDTH +: WIDTH];
                  row   <= '0;
                  state <= STREAM;
               end
            end
            STREAM: begin
               if (i_ready) begin
                  if (row == LAST_ROW) begin
                     // Counter returns to 0 so the idle outputs match reset.
                     row        <= '0;
                     state      <= IDLE;
                     frame_done <= 1'b1;
                  end else begin
                     row <= row + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign o_valid      = streaming;
   assign o_busy       = streaming;
   assign o_row_idx    = row;
   assign o_row_data   = streaming ? snap[row] : '0;
   assign o_last       = streaming && (row == LAST_ROW);
   assign o_frame_done = frame_done;

`ifdef GOL_READER_POPCOUNT_EN
   function automatic logic [POP_BITS-1:0] row_pop(input logic [WIDTH-1:0] d);
      logic [POP_BITS-1:0] n;
      n = '0;
      for (int i = 0; i < WIDTH; i++) n = n + POP_BITS'(d[i]);
      return n;
   endfunction

   logic [POP_BITS-1:0] pop;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         pop <= '0;
      end else if (!streaming && i_capture) begin
         pop <= '0;
      end else if (xfer) begin
         pop <= pop + row_pop(snap[row]);
      end
   end

   assign o_population = pop;
`else
   logic unused_xfer;
   assign unused_xfer = xfer;
`endif

endmodule

// File: tb/tb_gol_grid_reader.sv
// Directed self-checking bench for gol_grid_reader: glider, backpressure, isolation, capture-in-stream, reset abort.
module tb_gol_grid_reader;

   localparam int WIDTH    = 8;
   localparam int HEIGHT   = 8;
   localparam int ROW_BITS = 3;
   localparam int POP_BITS = 7;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [WIDTH*HEIGHT-1:0] cells;
   logic                    capture;
   logic                    ready;
   logic                    valid;
   logic [WIDTH-1:0]        row_data;
   logic [ROW_BITS-1:0]     row_idx;
   logic                    last;
   logic                    busy;
   logic                    frame_done;
`ifdef GOL_READER_POPCOUNT_EN
   logic [POP_BITS-1:0]     population;
`endif

   int checks = 0;
   int passed = 0;
   int failed = 0;

   logic [WIDTH-1:0] exp_rows [HEIGHT];

   always #5 clk = ~clk;

   gol_grid_reader #(
      .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ROW_BITS(ROW_BITS), .POP_BITS(POP_BITS)
   ) dut (
      .i_clk(clk),
      .i_reset(rst),
      .i_cells(cells),
      .i_capture(capture),
      .i_ready(ready),
      .o_valid(valid),
      .o_row_data(row_data),
      .o_row_idx(row_idx),
      .o_last(last),
      .o_busy(busy),
      .o_frame_done(frame_done)
`ifdef GOL_READER_POPCOUNT_EN
      ,
      .o_population(population)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_cells();
      for (int r = 0; r < HEIGHT; r++) cells[r*WIDTH +: WIDTH] = exp_rows[r];
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, 32'(valid), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_last"}, 32'(last), 0);
      check({tag, "_idx"}, 32'(row_idx), 0);
      check({tag, "_data"}, 32'(row_data), 0);
   endtask

   // Capture exp_rows and stream it with ready held high, checking every beat and the done pulse.
   task automatic run_frame(input string tag);
      load_cells();
      ready   = 1'b1;
      capture = 1'b1;
      tick();
      capture = 1'b0;
      for (int k = 0; k < HEIGHT; k++) begin
         check({tag, "_valid"}, 32'(valid), 1);
         check({tag, "_idx"}, 32'(row_idx), 32'(k));
         check({tag, "_data"}, 32'(row_data), 32'(exp_rows[k]));
         check({tag, "_last"}, 32'(last), (k == HEIGHT-1) ? 1 : 0);
         check({tag, "_done_early"}, 32'(frame_done), 0);
         tick();
      end
      check({tag, "_done"}, 32'(frame_done), 1);
      check({tag, "_valid_after"}, 32'(valid), 0);
      check({tag, "_busy_after"}, 32'(busy), 0);
   endtask

   initial begin
      rst     = 1'b1;
      cells   = '0;
      capture = 1'b0;
      ready   = 1'b0;
      #12;
      check_idle("rst_hold");
      check("rst_done", 32'(frame_done), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      tick();
      check_idle("post_rst");
`ifdef GOL_READER_POPCOUNT_EN
      check("post_rst_pop", 32'(population), 0);
`endif

      // Glider
      exp_rows = '{8'h02, 8'h04, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_frame("glider");
`ifdef GOL_READER_POPCOUNT_EN
      check("glider_pop", 32'(population), 5);
`endif
      tick();
      check("glider_done_pulse", 32'(frame_done), 0);
      check_idle("glider_idle");

      // Backpressure with ready pattern 1,0,0,1,0,1 repeating
      begin
         logic pat [6];
         int   exp_row;
         int   cyc;
         int   xfers;
         pat     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
         exp_rows = '{8'hA5, 8'h5A, 8'hA5, 8'h5A, 8'hA5, 8'h5A, 8'hA5, 8'h5A};
         load_cells();
         capture = 1'b1;
         tick();
         capture = 1'b0;
         exp_row = 0;
         cyc     = 0;
         xfers   = 0;
         while (exp_row < HEIGHT && cyc < 100) begin
            ready = pat[cyc % 6];
            check("bp_valid", 32'(valid), 1);
            check("bp_idx", 32'(row_idx), 32'(exp_row));
            check("bp_data", 32'(row_data), 32'(exp_rows[exp_row]));
            check("bp_last", 32'(last), (exp_row == HEIGHT-1) ? 1 : 0);
            check("bp_done_early", 32'(frame_done), 0);
            tick();
            if (pat[cyc % 6]) begin
               exp_row++;
               xfers++;
            end
            cyc++;
         end
         check("bp_timeout", (cyc < 100) ? 32'd0 : 32'd1, 0);
         check("bp_xfers", 32'(xfers), 8);
         check("bp_done", 32'(frame_done), 1);
         check("bp_valid_after", 32'(valid), 0);
         ready = 1'b1;
         tick();
      end

      // Snapshot isolation: live grid cleared right after the capture edge
      begin
         for (int r = 0; r < HEIGHT; r++) exp_rows[r] = 8'hFF;
         load_cells();
         capture = 1'b1;
         tick();
         capture = 1'b0;
         cells   = '0;
         for (int k = 0; k < HEIGHT; k++) begin
            check("iso_data", 32'(row_data), 32'hFF);
            check("iso_idx", 32'(row_idx), 32'(k));
            tick();
         end
         check("iso_done", 32'(frame_done), 1);
         tick();
      end

      // Capture pulses at beats 3 and 8 must be ignored
      begin
         int dones;
         for (int r = 0; r < HEIGHT; r++) exp_rows[r] = 8'(r * 17 + 1);
         load_cells();
         capture = 1'b1;
         tick();
         dones = 0;
         for (int k = 0; k < HEIGHT; k++) begin
            capture = (k == 2 || k == HEIGHT-1);
            cells   = {(WIDTH*HEIGHT){1'b1}};
            check("cap_idx", 32'(row_idx), 32'(k));
            check("cap_data", 32'(row_data), 32'(exp_rows[k]));
            tick();
         end
         capture = 1'b0;
         for (int c = 0; c < 4; c++) begin
            if (frame_done) dones++;
            if (c > 0) check("cap_valid_after", 32'(valid), 0);
            tick();
         end
         check("cap_done_count", 32'(dones), 1);
      end

      // Asynchronous reset during beat 4
      begin
         int dones;
         exp_rows = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
         load_cells();
         capture = 1'b1;
         tick();
         capture = 1'b0;
         tick();
         tick();
         tick();
         check("rm_idx_before", 32'(row_idx), 3);
         check("rm_data_before", 32'(row_data), 32'h44);
         #2 rst = 1'b1;
         #1;
         check_idle("rm_async");
         check("rm_done_async", 32'(frame_done), 0);
         @(posedge clk);
         #1 rst = 1'b0;
         dones = 0;
         for (int c = 0; c < 3; c++) begin
            if (frame_done) dones++;
            check("rm_valid_idle", 32'(valid), 0);
            tick();
         end
         check("rm_no_done", 32'(dones), 0);
         exp_rows = '{8'h01, 8'h80, 8'h03, 8'hC0, 8'h0F, 8'hF0, 8'h3C, 8'hC3};
         run_frame("rm_restart");
         tick();
      end

`ifdef GOL_READER_POPCOUNT_EN
      exp_rows = '{8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA};
      run_frame("pop_checker");
      check("pop_checker_val", 32'(population), 32);
      tick();
      tick();
      check("pop_checker_hold", 32'(population), 32);
      for (int r = 0; r < HEIGHT; r++) exp_rows[r] = 8'h00;
      load_cells();
      capture = 1'b1;
      tick();
      capture = 1'b0;
      check("pop_clear", 32'(population), 0);
      for (int k = 0; k < HEIGHT; k++) tick();
      check("pop_zero_done", 32'(frame_done), 1);
      check("pop_zero_val", 32'(population), 0);
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
